// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared width, fetch state encoding and flush value for the fetch stage
package fetch_stage_pkg;
  localparam int WORD_WIDTH = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;
  localparam logic [31:0] NOP = 32'h0;
endpackage

// File: rtl/fetch_if_id_reg.sv
// fetch_if_id_reg: IF/ID pipeline register with flush (priority over load), load and hold
module fetch_if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] pc_in,
  input  logic [W-1:0] instr_in,
  output logic [W-1:0] pc_out,
  output logic [W-1:0] instruction_out,
  output logic         valid_out
);
  import fetch_stage_pkg::*;
  // flush clears to a bubble, load captures a new instruction, otherwise hold
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_out <= '0;
      instruction_out <= NOP;
      valid_out <= 1'b0;
    end else if (flush) begin
      pc_out <= '0;
      instruction_out <= NOP;
      valid_out <= 1'b0;
    end else if (load) begin
      pc_out <= pc_in;
      instruction_out <= instr_in;
      valid_out <= 1'b1;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction-memory request FSM and IF/ID register feeding decode
module fetch_stage #(
  parameter int WORD_WIDTH = fetch_stage_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [WORD_WIDTH-1:0] branch_address,
  output logic                  imem_req,
  output logic [WORD_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  output logic [WORD_WIDTH-1:0] pc_out,
  output logic [WORD_WIDTH-1:0] instruction_out,
  output logic                  valid_out
);
  import fetch_stage_pkg::*;
  logic [1:0] state;
  logic run, fetched, load, flush;
  logic [WORD_WIDTH-1:0] pc, pc_next, redirect_pc, hold_instr, hold_pc;
  assign pc_next = pc + WORD_WIDTH'(PC_STEP);
  assign imem_req = state == ST_FETCH || state == ST_DISCARD;
  assign imem_addr = pc;
  assign fetched = state == ST_FETCH && imem_ack;
  assign load = !freeze && (fetched || state == ST_HOLD);
  assign flush = branch_taken || state == ST_IDLE || state == ST_DISCARD || (state == ST_FETCH && !imem_ack && !freeze);
  // run delays leaving IDLE by one edge after reset release; then redirect beats ack/freeze, else normal sequencing
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      run <= 1'b0;
      state <= ST_IDLE;
      pc <= RESET_PC;
      redirect_pc <= '0;
      hold_instr <= '0;
      hold_pc <= '0;
    end else if (!run) run <= 1'b1;
    else if (branch_taken) begin
      if (imem_req && !imem_ack) begin
        redirect_pc <= branch_address;
        state <= ST_DISCARD;
      end else begin
        pc <= branch_address;
        hold_instr <= '0;
        hold_pc <= '0;
        state <= ST_FETCH;
      end
    end else
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH:
          if (imem_ack) begin
            pc <= pc_next;
            if (freeze) begin
              hold_instr <= imem_rdata;
              hold_pc <= pc_next;
              state <= ST_HOLD;
            end
          end
        ST_HOLD: if (!freeze) state <= ST_FETCH;
        default:
          if (imem_ack) begin
            pc <= redirect_pc;
            state <= ST_FETCH;
          end
      endcase
  fetch_if_id_reg #(.W(WORD_WIDTH)) u_if_id (
    .clk(clk),
    .rst(rst),
    .load(load),
    .flush(flush),
    .pc_in(fetched ? pc_next : hold_pc),
    .instr_in(fetched ? imem_rdata : hold_instr),
    .pc_out(pc_out),
    .instruction_out(instruction_out),
    .valid_out(valid_out)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard for free-running fetches plus a cycle table for branch/freeze corner cases
module tb_fetch_stage;
  logic clk, rst, freeze, branch_taken, imem_req, imem_ack, valid_out;
  logic [31:0] branch_address, imem_addr, imem_rdata, pc_out, instruction_out;
  logic req_w, ack_w, valid_w;
  logic [31:0] addr_w, pc_w, instr_w;
  logic mem_mode, ack_block, t_ack, freeze_q;
  logic [31:0] t_rdata;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct { logic [31:0] pc, instr; } exp_t;
  typedef struct {
    logic fr, br; logic [31:0] ba; logic ack; logic [31:0] rd;
    logic exp_req; logic [31:0] exp_addr; logic exp_valid; logic [31:0] exp_instr, exp_pc;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[17];

  function automatic logic [31:0] word(logic [31:0] a);
    return a == 32'd8 ? 32'hE3A0_1005 : a ^ 32'h5A00_0000;
  endfunction

  assign imem_ack = mem_mode ? imem_req && !ack_block : t_ack;
  assign imem_rdata = mem_mode ? word(imem_addr) : t_rdata;
  assign ack_w = req_w;

  fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken), .branch_address(branch_address),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instruction_out(instruction_out), .valid_out(valid_out)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst), .freeze(1'b0), .branch_taken(1'b0), .branch_address(32'h0),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w), .imem_rdata(32'h0),
    .pc_out(pc_w), .instruction_out(instr_w), .valid_out(valid_w)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) freeze_q <= freeze;

  always @(posedge clk)
    if (mem_mode && rst && imem_req && imem_ack) sb.push_back('{imem_addr + 32'd4, imem_rdata});

  always @(negedge clk)
    if (mem_mode && rst && valid_out && !freeze_q) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected nothing", pc_out, instruction_out);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", pc_out, e.pc);
        chk("sb_instr", instruction_out, e.instr);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 0, 32'h0,   1, 32'hA000_0000, 1, 32'h10,  1, 32'hA000_0000, 32'h10};
    tbl[1]  = '{0, 0, 32'h0,   0, 32'h0,         1, 32'h10,  0, 32'h0,         32'h0};
    tbl[2]  = '{0, 1, 32'h100, 0, 32'h0,         1, 32'h10,  0, 32'h0,         32'h0};
    tbl[3]  = '{0, 0, 32'h0,   1, 32'hDEAD_BEEF, 1, 32'h100, 0, 32'h0,         32'h0};
    tbl[4]  = '{0, 0, 32'h0,   1, 32'hB000_0000, 1, 32'h104, 1, 32'hB000_0000, 32'h104};
    tbl[5]  = '{0, 1, 32'h100, 0, 32'h0,         1, 32'h104, 0, 32'h0,         32'h0};
    tbl[6]  = '{0, 1, 32'h200, 0, 32'h0,         1, 32'h104, 0, 32'h0,         32'h0};
    tbl[7]  = '{1, 0, 32'h0,   0, 32'h0,         1, 32'h104, 0, 32'h0,         32'h0};
    tbl[8]  = '{0, 0, 32'h0,   1, 32'hDEAD_BEEF, 1, 32'h200, 0, 32'h0,         32'h0};
    tbl[9]  = '{0, 0, 32'h0,   1, 32'hC000_0000, 1, 32'h204, 1, 32'hC000_0000, 32'h204};
    tbl[10] = '{1, 1, 32'h300, 1, 32'hDEAD_BEEF, 1, 32'h300, 0, 32'h0,         32'h0};
    tbl[11] = '{0, 0, 32'h0,   1, 32'hD000_0000, 1, 32'h304, 1, 32'hD000_0000, 32'h304};
    tbl[12] = '{1, 0, 32'h0,   1, 32'hE000_0000, 0, 32'h308, 1, 32'hD000_0000, 32'h304};
    tbl[13] = '{1, 1, 32'h400, 0, 32'h0,         1, 32'h400, 0, 32'h0,         32'h0};
    tbl[14] = '{0, 0, 32'h0,   1, 32'hF000_0000, 1, 32'h404, 1, 32'hF000_0000, 32'h404};
    tbl[15] = '{1, 0, 32'h0,   0, 32'h0,         1, 32'h404, 1, 32'hF000_0000, 32'h404};
    tbl[16] = '{0, 0, 32'h0,   0, 32'h0,         1, 32'h404, 0, 32'h0,         32'h0};
    rst = 1; freeze = 0; branch_taken = 0; branch_address = 0;
    mem_mode = 1; ack_block = 0; t_ack = 0; t_rdata = 0;
    #2 rst = 0;
    tick;
    tick;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_valid", 32'(valid_out), 32'h0);
    chk("rst_addr_w", addr_w, 32'hFFFF_FFF8);
    @(negedge clk) rst = 1;
    tick;
    chk("e1_req_idle", 32'(imem_req), 32'h0);
    tick;
    chk("e2_req", 32'(imem_req), 32'h1);
    chk("e2_addr", imem_addr, 32'h0);
    chk("e2_addr_w", addr_w, 32'hFFFF_FFF8);
    tick;
    chk("e3_addr", imem_addr, 32'h4);
    chk("e3_addr_w", addr_w, 32'hFFFF_FFFC);
    tick;
    chk("e4_addr", imem_addr, 32'h8);
    chk("e4_addr_w_wrap", addr_w, 32'h0);
    freeze = 1;
    tick;
    chk("hold_req", 32'(imem_req), 32'h0);
    chk("hold_ifid_instr", instruction_out, 32'h5A00_0004);
    chk("hold_ifid_pc", pc_out, 32'h8);
    tick;
    chk("hold_req2", 32'(imem_req), 32'h0);
    tick;
    freeze = 0;
    tick;
    chk("release_req", 32'(imem_req), 32'h1);
    chk("release_addr", imem_addr, 32'hC);
    chk("release_instr", instruction_out, 32'hE3A0_1005);
    chk("release_pc", pc_out, 32'hC);
    ack_block = 1;
    tick;
    mem_mode = 0;
    chk("sb_empty", 32'(sb.size()), 32'h0);
    for (int i = 0; i < 17; i++) begin
      freeze = tbl[i].fr;
      branch_taken = tbl[i].br;
      branch_address = tbl[i].ba;
      t_ack = tbl[i].ack;
      t_rdata = tbl[i].rd;
      tick;
      chk($sformatf("row%0d_req", i), 32'(imem_req), 32'(tbl[i].exp_req));
      chk($sformatf("row%0d_addr", i), imem_addr, tbl[i].exp_addr);
      chk($sformatf("row%0d_valid", i), 32'(valid_out), 32'(tbl[i].exp_valid));
      chk($sformatf("row%0d_instr", i), instruction_out, tbl[i].exp_instr);
      if (tbl[i].exp_valid || tbl[i].br) chk($sformatf("row%0d_pc", i), pc_out, tbl[i].exp_pc);
    end
    freeze = 0; branch_taken = 0; branch_address = 0;
    t_ack = 1; t_rdata = 32'h1234_5678;
    rst = 0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_valid", 32'(valid_out), 32'h0);
    chk("midrst_instr", instruction_out, 32'h0);
    chk("midrst_pc", pc_out, 32'h0);
    chk("midrst_addr_w", addr_w, 32'hFFFF_FFF8);
    @(negedge clk) rst = 1;
    tick;
    chk("post_e1_req", 32'(imem_req), 32'h0);
    chk("post_e1_valid", 32'(valid_out), 32'h0);
    tick;
    chk("post_e2_req", 32'(imem_req), 32'h1);
    chk("post_e2_addr", imem_addr, 32'h0);
    chk("post_e2_valid", 32'(valid_out), 32'h0);
    tick;
    chk("post_e3_valid", 32'(valid_out), 32'h1);
    chk("post_e3_instr", instruction_out, 32'h1234_5678);
    chk("post_e3_pc", pc_out, 32'h4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
